// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: ALU opcodes and default datapath width.
// Used by the ALU control decoder and the execute-stage ALU.
package mips_defs;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic ovf;
        logic ill;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU: maps (a, b, op) to result, signed overflow and illegal flag.
// Overflow is only meaningful for add/sub; slt uses the overflow-corrected sign.
module alu_core
    import mips_defs::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_illegal
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_lt;
    logic             w_sa;
    logic             w_sb;

    assign w_sa   = i_a[WIDTH-1];
    assign w_sb   = i_b[WIDTH-1];
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    assign w_ovf_add = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
    assign w_ovf_sub = (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa);

    // Raw difference sign is wrong exactly when the subtraction overflowed.
    assign w_lt = w_diff[WIDTH-1] ^ w_ovf_sub;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result   = w_sum;
                o_overflow = w_ovf_add;
            end
            ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = w_ovf_sub;
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: operand capture register, combinational ALU, result register.
// Valid/ready on both sides; a stalled output backs up into the capture stage.
module alu_exec
    import mips_defs::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [2:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    alu_flags_t       r_flags;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;

    // Stage 2 frees up when empty or drained this cycle.
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
    assign w_s1_load = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_result   (w_res),
        .o_overflow (w_flags.ovf),
        .o_illegal  (w_flags.ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= ALU_AND;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_a        <= srca;
            r_b        <= srcb;
            r_op       <= alucontrol;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_flags     <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_flags     <= w_flags;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_flags.ovf;
    assign illegal   = r_flags.ill;

endmodule
